vec_ctrl_pipe_skid: RTL and testbench

//  Parametrised control-bundle pipeline register for the vector CPU datapath. Replaces the plain enable-gated stage.

---
 rtl/vec_cpu_pkg.sv | 20 ++
 rtl/vec_ctrl_skid_slot.sv | 61 ++++++
 rtl/vec_ctrl_pipe_skid.sv | 73 +++++++
 tb/tb_vec_ctrl_pipe_skid.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/vec_cpu_pkg.sv
// Shared vector-CPU control types.
//   ctrl_word_t : packed decode control bundle carried down the pipe
//   CTRL_W_DEF  : width of ctrl_word_t
//   NOP_CTRL    : bubble word (no writes, no stores)
package vec_cpu_pkg;

  typedef struct packed {
    logic       alu_st;
    logic       mem_st;
    logic       shift_op;
    logic [1:0] mem_op;
    logic [1:0] esc_wr;
    logic [1:0] vec_wr;
    logic [3:0] alu_op;
  } ctrl_word_t;

  localparam int         CTRL_W_DEF = $bits(ctrl_word_t);
  localparam ctrl_word_t NOP_CTRL   = '0;

endpackage

// File: rtl/vec_ctrl_skid_slot.sv
// One ready/valid skid slot: a main register plus a one-entry skid buffer.
// Ports:
//   clk, reset      : clock (state on negedge), sync active-high reset
//   flush           : kills main and skid entries at the edge
//   in_valid/in_ready/in_ctrl    : upstream handshake; in_ready = ~skid_v
//   out_valid/out_ready/out_ctrl : downstream handshake; out_ctrl is
//                                  NOP_WORD while out_valid=0
module vec_ctrl_skid_slot #(
  parameter int                CTRL_W   = 13,
  parameter logic [CTRL_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl
);

  logic              main_v, skid_v;
  logic [CTRL_W-1:0] main_d, skid_d;
  logic              push, pop;

  // Ready depends only on local state, so no combinational path runs
  // from out_ready back up the chain.
  assign in_ready  = ~skid_v;
  assign push      = in_valid & in_ready;
  assign pop       = main_v & out_ready;
  assign out_valid = main_v;
  assign out_ctrl  = main_v ? main_d : NOP_WORD;

  // Data registers are not reset; they are masked by the valid bits.
  always_ff @(negedge clk) begin
    if (reset || flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (pop) begin
      if (skid_v) begin
        // push cannot coincide here: in_ready was low
        main_d <= skid_d;
        skid_v <= 1'b0;
      end else if (push) begin
        main_d <= in_ctrl;
      end else begin
        main_v <= 1'b0;
      end
    end else if (push) begin
      if (main_v) begin
        skid_d <= in_ctrl;
        skid_v <= 1'b1;
      end else begin
        main_d <= in_ctrl;
        main_v <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/vec_ctrl_pipe_skid.sv
// Control-bundle pipeline for the vector CPU: NUM_STAGES chained skid slots
// between decode and ALU/MEM/WB.
// Ports:
//   clk, reset   : clock (state on negedge), sync active-high reset
//   flush        : drops every in-flight word, same-cycle input discarded
//   in_valid/in_ready/in_ctrl    : decode side
//   out_valid/out_ready/out_ctrl : execute side, NOP_WORD when idle
//   stall_cnt    : saturating out_valid&~out_ready cycle count, present
//                  only when VEC_CTRL_PIPE_PERF_EN is defined
module vec_ctrl_pipe_skid
  import vec_cpu_pkg::*;
#(
  parameter int                CTRL_W     = CTRL_W_DEF,
  parameter int                NUM_STAGES = 2,
  parameter logic [CTRL_W-1:0] NOP_WORD   = CTRL_W'(NOP_CTRL)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef VEC_CTRL_PIPE_PERF_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  // Index k is the input side of slot k; index NUM_STAGES is the pipe output.
  logic [NUM_STAGES:0]             vld_pipe;
  logic [NUM_STAGES:0]             rdy_pipe;
  logic [NUM_STAGES:0][CTRL_W-1:0] ctrl_pipe;

  assign vld_pipe[0]          = in_valid;
  assign ctrl_pipe[0]         = in_ctrl;
  assign rdy_pipe[NUM_STAGES] = out_ready;
  assign in_ready             = rdy_pipe[0];
  assign out_valid            = vld_pipe[NUM_STAGES];
  assign out_ctrl             = ctrl_pipe[NUM_STAGES];

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_slot
    vec_ctrl_skid_slot #(
      .CTRL_W   (CTRL_W),
      .NOP_WORD (NOP_WORD)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (vld_pipe[k]),
      .in_ready  (rdy_pipe[k]),
      .in_ctrl   (ctrl_pipe[k]),
      .out_valid (vld_pipe[k+1]),
      .out_ready (rdy_pipe[k+1]),
      .out_ctrl  (ctrl_pipe[k+1])
    );
  end

`ifdef VEC_CTRL_PIPE_PERF_EN
  // Survives flush on purpose: it measures stalls across pipeline kills.
  logic [31:0] stall_q;
  always_ff @(negedge clk) begin
    if (reset)
      stall_q <= '0;
    else if (out_valid && !out_ready && stall_q != 32'hFFFF_FFFF)
      stall_q <= stall_q + 32'd1;
  end
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_vec_ctrl_pipe_skid.sv
module tb_vec_ctrl_pipe_skid;

  localparam int W = 13;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_ctrl, out_ctrl;
`ifdef VEC_CTRL_PIPE_PERF_EN
  logic [31:0]  stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  vec_ctrl_pipe_skid dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl)
`ifdef VEC_CTRL_PIPE_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst, fl, iv, ordy;
    logic [W-1:0] d;
    logic         e_ov, e_ir;
    logic [W-1:0] e_oc;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(logic rst, logic fl, logic iv, logic [W-1:0] d,
                              logic ordy, logic e_ov, logic [W-1:0] e_oc, logic e_ir);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ov = e_ov; v.e_oc = e_oc; v.e_ir = e_ir;
    return v;
  endfunction

  // Advance one state-update edge; sample/drive #1 after it.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic fl, logic iv, logic [W-1:0] d, logic ordy);
    reset = rst; flush = fl; in_valid = iv; in_ctrl = d; out_ready = ordy;
  endtask

  // Stall the output and keep pushing until in_ready drops; returns words accepted.
  task automatic fill(input logic [W-1:0] base, output int acc);
    acc = 0;
    for (int c = 0; c < 12 && in_ready; c++) begin
      drive(0, 0, 1, base + W'(acc), 0);
      acc++;
      tick();
    end
    drive(0, 0, 0, '0, 0);
  endtask

  logic [W-1:0] sb[$];
  int           acc, pops;
  logic [W-1:0] held;

  initial begin
    drive(1, 0, 0, '0, 1);

    // reset
    tbl[0]  = mk(1,0,1,13'h0AA,1, 0,13'h000,1);
    tbl[1]  = mk(1,0,1,13'h0AA,1, 0,13'h000,1);
    // back-to-back stream, 2-edge latency
    tbl[2]  = mk(0,0,1,13'h001,1, 0,13'h000,1);
    for (int i = 0; i < 9; i++)
      tbl[3+i] = mk(0,0,1,W'(i+2),1, 1,W'(i+1),1);
    tbl[12] = mk(0,0,0,13'h000,1, 1,13'h00A,1);
    tbl[13] = mk(0,0,0,13'h000,1, 0,13'h000,1);
    // flush on empty pipe with in_ready=1: word discarded
    tbl[14] = mk(0,1,1,13'h1FF,1, 0,13'h000,1);
    tbl[15] = mk(0,0,0,13'h000,1, 0,13'h000,1);
    tbl[16] = mk(0,0,0,13'h000,1, 0,13'h000,1);
    // bubbles show NOP, not stale data
    tbl[17] = mk(0,0,1,13'h0A1,1, 0,13'h000,1);
    tbl[18] = mk(0,0,0,13'h000,1, 1,13'h0A1,1);
    tbl[19] = mk(0,0,1,13'h0A2,1, 0,13'h000,1);
    tbl[20] = mk(0,0,0,13'h000,1, 1,13'h0A2,1);
    tbl[21] = mk(0,0,0,13'h000,1, 0,13'h000,1);
    // single word held by out_ready=0
    tbl[22] = mk(0,0,1,13'h0B1,0, 0,13'h000,1);
    tbl[23] = mk(0,0,0,13'h000,0, 1,13'h0B1,1);
    tbl[24] = mk(0,0,0,13'h000,0, 1,13'h0B1,1);
    tbl[25] = mk(0,0,0,13'h000,1, 0,13'h000,1);

    tick();
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      tick();
      chk($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("v%0d.out_ctrl", i),  32'(out_ctrl),  32'(tbl[i].e_oc));
      chk($sformatf("v%0d.in_ready", i),  32'(in_ready),  32'(tbl[i].e_ir));
    end

    // Backpressure: stall from cycle 3, capacity 2*NUM_STAGES, then drain.
    acc = 0;
    for (int c = 1; c <= 8; c++) begin
      drive(0, 0, 1, 13'h100 + W'(acc), c < 3);
      if (in_ready) begin sb.push_back(in_ctrl); acc++; end
      tick();
    end
    chk("bp.accepted", 32'(acc), 32'd4);
    chk("bp.in_ready_low", 32'(in_ready), 32'd0);
    chk("bp.held_word", 32'(out_ctrl), 32'h100);
    pops = 0;
    drive(0, 0, 0, '0, 1);
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      if (out_valid) begin
        held = sb.pop_front();
        chk($sformatf("bp.drain%0d", pops), 32'(out_ctrl), 32'(held));
        pops++;
      end
      tick();
    end
    chk("bp.pops", 32'(pops), 32'd4);
    chk("bp.empty_after", 32'(out_valid), 32'd0);

    // Flush mid-stall with a same-cycle input.
    fill(13'h110, acc);
    chk("fl.fill", 32'(acc), 32'd4);
    drive(0, 1, 1, 13'h1FF, 0);
    tick();
    chk("fl.out_valid", 32'(out_valid), 32'd0);
    chk("fl.out_ctrl", 32'(out_ctrl), 32'd0);
    chk("fl.in_ready", 32'(in_ready), 32'd1);
    drive(0, 0, 0, '0, 1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("fl.quiet%0d", c), 32'(out_valid), 32'd0);
    end

    // Reset and flush together on full buffers, then a fresh word.
    fill(13'h120, acc);
    drive(1, 1, 1, 13'h0EE, 0);
    tick();
    chk("rf.out_valid", 32'(out_valid), 32'd0);
    chk("rf.in_ready", 32'(in_ready), 32'd1);
    drive(0, 0, 1, 13'h055, 1);
    tick();
    chk("rf.lat1", 32'(out_valid), 32'd0);
    drive(0, 0, 0, '0, 1);
    tick();
    chk("rf.lat2_valid", 32'(out_valid), 32'd1);
    chk("rf.lat2_ctrl", 32'(out_ctrl), 32'h055);
    tick();
    chk("rf.gone", 32'(out_valid), 32'd0);

`ifdef VEC_CTRL_PIPE_PERF_EN
    drive(1, 0, 0, '0, 1);
    tick();
    chk("perf.reset", stall_cnt, 32'd0);
    drive(0, 0, 1, 13'h077, 1);
    tick();
    drive(0, 0, 0, '0, 1);
    tick();
    drive(0, 0, 0, '0, 0);
    for (int c = 0; c < 7; c++) tick();
    chk("perf.held", 32'(out_ctrl), 32'h077);
    drive(0, 1, 0, '0, 1);
    tick();
    chk("perf.seven", stall_cnt, 32'd7);
    drive(0, 0, 1, 13'h078, 0);
    tick();
    drive(0, 0, 0, '0, 0);
    tick();
    dut.stall_q = 32'hFFFF_FFFD;
    for (int c = 0; c < 5; c++) tick();
    chk("perf.saturate", stall_cnt, 32'hFFFF_FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
